obj_motion_ctrl: RTL and testbench
==================================

Name: obj_motion_ctrl

Overview:
- Per-object trajectory sequencer for the fruit sprites. Drives the posx/posy inputs of one sprite renderer (displayObj) once per video frame.
- Accepts a launch command, integrates position and gravity on each frame tick, and applies independent X/Y update periods (Tx, Ty).
- Handles a slice event and reports when the object has left the screen.
- One instance per fruit; a top-level spawner issues launch and slice commands.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- GRAVITY, 1, added to vy on every Y update (signed, small positive)

Ports:
- clk  in  1  system clock (same domain as the renderer clock)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at the start of vertical blank
- launch  in  1  one-cycle launch request
- launch_x  in  10  initial X, left edge of the sprite
- launch_vx  in  8  signed initial X velocity, px per X update
- launch_vy  in  8  signed initial Y velocity; negative means upward
- Tx  in  32  frames per X update (0 treated as 1)
- Ty  in  32  frames per Y update (0 treated as 1)
- width  in  10  sprite width in pixels
- height  in  9  sprite height in pixels
- slice  in  1  one-cycle slice event
- posx  out  10  clamped X for the renderer
- posy  out  9  clamped Y for the renderer
- visible  out  1  sprite rectangle overlaps the screen
- busy  out  1  object in flight
- sliced  out  1  object has been sliced this flight
- done  out  1  one-cycle pulse when the flight ends

Behaviour:
- Reset values: posx=0, posy=0, visible=0, busy=0, sliced=0, done=0. State=IDLE. Frame counters=0. Velocity registers=0.
- Internal position: signed 12-bit x and signed 11-bit y, so off-screen positions are representable. vx and vy are signed 8-bit; vy saturates at +127 and -128.
- State IDLE:
  - launch=1 loads x=launch_x, y=SCREEN_H, vx, vy, and clears both frame counters and sliced.
  - Moves to FLY; busy=1 from the next cycle.
  - A frame_tick in the same cycle as launch is not applied.
- State FLY, on frame_tick (cycle t), registered at t+1:
  - cx increments. When cx reaches max(Tx,1)-1: x += vx and cx=0.
  - cy increments. When cy reaches max(Ty,1)-1: y += vy, vy += GRAVITY, and cy=0.
  - Go to CHECK.
- State CHECK (cycle t+1), exit conditions:
  - (y >= SCREEN_H and vy > 0), or
  - x >= SCREEN_W, or
  - x + width <= 0.
  - On exit: done=1 for exactly this cycle's next edge (done high in cycle t+2), busy=0, go to IDLE.
  - Otherwise return to FLY.
- Slice:
  - Accepted in FLY or CHECK only: sliced=1, vy = max(vy,0).
  - Slice in the same cycle as an update: applied to the post-update vy.
  - Ignored in IDLE. Repeated slices have no further effect.
- launch while busy=1 is ignored; no queuing.
- posx = clamp(x, 0, SCREEN_W-1); posy = clamp(y, 0, SCREEN_H-1). Both are registered and change only in the cycle after a position change.
- visible = (x < SCREEN_W) and (x + width > 0) and (y < SCREEN_H) and (y + height > 0). visible=0 in IDLE.
- frame_tick while in CHECK cannot occur: ticks are at least one line apart. The bench must still not see a lost or double update if ticks are spaced ≥ 2 cycles apart.
- rst mid-flight: all outputs return to reset values on the next edge, with no done pulse.

Optional Feature:
- Macro: OBJ_MOTION_WRAP_X_EN
- Defined:
  - Horizontal exits are disabled.
  - x >= SCREEN_W wraps to x = -width.
  - x + width <= 0 wraps to x = SCREEN_W-1.
  - Wrapping is applied in CHECK; only the vertical exit ends the flight.
- Undefined: behaviour exactly as above; horizontal exits end the flight.

Test Plan:
- Basic flight:
  - Stimulus: launch_x=100, vx=2, vy=-10, Tx=Ty=1, GRAVITY=1.
  - After tick 1: posy=470, posx=102.
  - After tick 10: posy=425.
  - Tick 21: y=480, vy=11, done pulse two cycles after the tick, busy=0, posx=142.
- Tx=2, Ty=1, same launch:
  - posx steps 100→100→102→102→104 over ticks 1-4.
  - posy follows the same sequence as the basic flight.
- Slice:
  - Stimulus: basic launch, slice after tick 3 (y=453, vy=-7).
  - Required: sliced=1, vy=0; tick 4 leaves posy=453; tick 5 gives posy=454.
- Busy and idle guards:
  - Second launch during flight is ignored (trajectory unchanged).
  - Slice in IDLE leaves sliced=0.
  - Tx=0 and Ty=0 behave as Tx=Ty=1.
- Exits and reset:
  - launch_x=630, vx=20, width=30: exit after tick 1 (x=650 ≥ 640); with OBJ_MOTION_WRAP_X_EN, x wraps to -30 and visible=0 until x > -30.
  - rst asserted at tick 5 of a flight: all outputs zero next cycle, no done pulse.

Source files
------------

// File: rtl/obj_motion_ctrl.sv
// obj_motion_ctrl: per-fruit trajectory sequencer driving one sprite renderer once per frame.
// Define OBJ_MOTION_WRAP_X_EN to wrap horizontally instead of ending the flight at the side edges.
module obj_motion_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        launch,
  input  logic [9:0]  launch_x,
  input  logic [7:0]  launch_vx,
  input  logic [7:0]  launch_vy,
  input  logic [31:0] Tx,
  input  logic [31:0] Ty,
  input  logic [9:0]  width,
  input  logic [8:0]  height,
  input  logic        slice,
  output logic [9:0]  posx,
  output logic [8:0]  posy,
  output logic        visible,
  output logic        busy,
  output logic        sliced,
  output logic        done
);
  localparam logic signed [11:0] XW = 12'(SCREEN_W);
  localparam logic signed [10:0] YH = 11'(SCREEN_H);
  localparam logic signed [8:0]  G9 = 9'(GRAVITY);
  typedef enum logic [1:0] {IDLE, FLY, CHECK} state_t;
  state_t state, state_n;
  logic signed [11:0] x, x_n;
  logic signed [10:0] y, y_n;
  logic signed [7:0]  vx, vx_n, vy, vy_n, vy_sat;
  logic signed [8:0]  vy_g;
  logic signed [12:0] xw;
  logic signed [11:0] yh;
  logic [31:0] cx, cx_n, cy, cy_n, tx_m1, ty_m1;
  logic upd_x, upd_y, exit_h, exit_v, sliced_n, done_n, vis_c;
  logic [9:0] posx_c;
  logic [8:0] posy_c;
  assign busy   = state != IDLE;
  assign tx_m1  = (Tx == 32'd0) ? 32'd0 : Tx - 32'd1;
  assign ty_m1  = (Ty == 32'd0) ? 32'd0 : Ty - 32'd1;
  assign upd_x  = cx >= tx_m1;
  assign upd_y  = cy >= ty_m1;
  assign vy_g   = 9'(vy) + G9;
  assign vy_sat = (vy_g > 9'sd127) ? 8'sh7f : (vy_g < -9'sd128) ? 8'sh80 : vy_g[7:0];
  assign xw     = 13'(x) + $signed({3'b0, width});
  assign yh     = 12'(y) + $signed({3'b0, height});
  assign exit_v = (y >= YH) && (vy > 8'sd0);
`ifdef OBJ_MOTION_WRAP_X_EN
  assign exit_h = 1'b0;
`else
  assign exit_h = (x >= XW) || (xw <= 13'sd0);
`endif
  assign vis_c  = busy && (x < XW) && (xw > 13'sd0) && (y < YH) && (yh > 12'sd0);
  assign posx_c = (x < 12'sd0) ? 10'd0 : (x >= XW) ? 10'(SCREEN_W - 1) : x[9:0];
  assign posy_c = (y < 11'sd0) ? 9'd0 : (y >= YH) ? 9'(SCREEN_H - 1) : y[8:0];
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    vx_n     = vx;
    vy_n     = vy;
    cx_n     = cx;
    cy_n     = cy;
    sliced_n = sliced;
    done_n   = 1'b0;
    case (state)
      IDLE: if (launch) begin
        state_n  = FLY;
        x_n      = {2'b0, launch_x};
        y_n      = YH;
        vx_n     = launch_vx;
        vy_n     = launch_vy;
        cx_n     = '0;
        cy_n     = '0;
        sliced_n = 1'b0;
      end
      FLY: if (frame_tick) begin
        state_n = CHECK;
        cx_n    = upd_x ? 32'd0 : cx + 32'd1;
        x_n     = upd_x ? x + 12'(vx) : x;
        cy_n    = upd_y ? 32'd0 : cy + 32'd1;
        y_n     = upd_y ? y + 11'(vy) : y;
        vy_n    = upd_y ? vy_sat : vy;
      end
      CHECK: begin
        state_n = (exit_v || exit_h) ? IDLE : FLY;
        done_n  = exit_v || exit_h;
`ifdef OBJ_MOTION_WRAP_X_EN
        x_n = (x >= XW) ? -$signed({2'b0, width}) : (xw <= 13'sd0) ? XW - 12'sd1 : x;
`endif
      end
      default: state_n = IDLE;
    endcase
    // slice acts on the post-update vy so a same-cycle update is not lost
    if (slice && state != IDLE) begin
      sliced_n = 1'b1;
      vy_n     = (vy_n < 8'sd0) ? 8'sd0 : vy_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      vx      <= '0;
      vy      <= '0;
      cx      <= '0;
      cy      <= '0;
      sliced  <= 1'b0;
      done    <= 1'b0;
      posx    <= '0;
      posy    <= '0;
      visible <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      vx      <= vx_n;
      vy      <= vy_n;
      cx      <= cx_n;
      cy      <= cy_n;
      sliced  <= sliced_n;
      done    <= done_n;
      posx    <= posx_c;
      posy    <= posy_c;
      visible <= vis_c;
    end
  end
endmodule

// File: tb/tb_obj_motion_ctrl.sv
// tb_obj_motion_ctrl: directed self-checking bench for obj_motion_ctrl.
module tb_obj_motion_ctrl;
  logic clk = 1'b0;
  logic rst, frame_tick, launch, slice;
  logic [9:0] launch_x, width;
  logic [7:0] launch_vx, launch_vy;
  logic [31:0] Tx, Ty;
  logic [8:0] height;
  logic [9:0] posx;
  logic [8:0] posy;
  logic visible, busy, sliced, done;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  obj_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
    .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
    .Tx(Tx), .Ty(Ty), .width(width), .height(height), .slice(slice),
    .posx(posx), .posy(posy), .visible(visible), .busy(busy),
    .sliced(sliced), .done(done)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic reset_dut();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic launch_obj(input int lx, input int lvx, input int lvy, input int tx, input int ty);
    @(negedge clk);
    launch_x  = 10'(lx);
    launch_vx = 8'(lvx);
    launch_vy = 8'(lvy);
    Tx        = 32'(tx);
    Ty        = 32'(ty);
    launch    = 1'b1;
    @(negedge clk) launch = 1'b0;
  endtask
  // tick at edge P1, CHECK decides at P2; sampling happens between P2 and P3
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask
  task automatic pulse_slice();
    @(negedge clk) slice = 1'b1;
    @(negedge clk) slice = 1'b0;
  endtask
  initial begin
    int ex_x[4] = '{100, 102, 102, 104};
    int ex_y[4] = '{470, 461, 453, 446};
    rst = 1'b1; frame_tick = 1'b0; launch = 1'b0; slice = 1'b0;
    launch_x = '0; launch_vx = '0; launch_vy = '0; Tx = '0; Ty = '0;
    width = 10'd30; height = 9'd20;
    repeat (2) @(negedge clk);
    chk("rst_posx", posx, 0);
    chk("rst_posy", posy, 0);
    chk("rst_visible", visible, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sliced", sliced, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    // basic flight
    launch_obj(100, 2, -10, 1, 1);
    chk("basic_busy", busy, 1);
    chk("basic_vis0", visible, 0);
    tick();
    chk("basic_t1_posx", posx, 102);
    chk("basic_t1_posy", posy, 470);
    chk("basic_t1_vis", visible, 1);
    chk("basic_t1_done", done, 0);
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (i == 10) chk("basic_t10_posy", posy, 425);
    end
    chk("basic_t20_done", done, 0);
    chk("basic_t20_busy", busy, 1);
    tick();
    chk("basic_t21_done", done, 1);
    chk("basic_t21_busy", busy, 0);
    chk("basic_t21_posx", posx, 142);
    chk("basic_t21_posy", posy, 479);
    chk("basic_t21_vis", visible, 0);
    @(negedge clk);
    chk("basic_done_pulse", done, 0);
    // Tx=2, Ty=1
    reset_dut();
    launch_obj(100, 2, -10, 2, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tx2_posx", posx, ex_x[i]);
      chk("tx2_posy", posy, ex_y[i]);
    end
    // second launch while busy is ignored
    reset_dut();
    launch_obj(100, 2, -10, 1, 1);
    tick();
    tick();
    launch_obj(300, 5, -50, 1, 1);
    tick();
    chk("busy_guard_posx", posx, 106);
    chk("busy_guard_posy", posy, 453);
    // slice
    reset_dut();
    launch_obj(100, 2, -10, 1, 1);
    repeat (3) tick();
    chk("slice_pre_posy", posy, 453);
    chk("slice_pre_sliced", sliced, 0);
    pulse_slice();
    chk("slice_sliced", sliced, 1);
    tick();
    chk("slice_t4_posy", posy, 453);
    tick();
    chk("slice_t5_posy", posy, 454);
    // slice in idle
    reset_dut();
    pulse_slice();
    chk("idle_slice", sliced, 0);
    chk("idle_busy", busy, 0);
    // zero periods act as one
    launch_obj(100, 2, -10, 0, 0);
    tick();
    chk("t0_t1_posx", posx, 102);
    chk("t0_t1_posy", posy, 470);
    tick();
    chk("t0_t2_posx", posx, 104);
    chk("t0_t2_posy", posy, 461);
    // right-edge exit / wrap
    reset_dut();
    launch_obj(630, 20, -10, 1, 1);
    tick();
`ifdef OBJ_MOTION_WRAP_X_EN
    chk("wrap_done", done, 0);
    chk("wrap_busy", busy, 1);
    @(negedge clk);
    chk("wrap_vis", visible, 0);
    chk("wrap_posx", posx, 0);
    tick();
    chk("wrap_t2_vis", visible, 1);
    chk("wrap_t2_posx", posx, 0);
`else
    chk("exit_done", done, 1);
    chk("exit_busy", busy, 0);
    chk("exit_posx", posx, 639);
    chk("exit_vis", visible, 0);
`endif
    // reset mid-flight at tick 5
    reset_dut();
    launch_obj(100, 2, -10, 1, 1);
    repeat (4) tick();
    pulse_slice();
    chk("midrst_pre_sliced", sliced, 1);
    @(negedge clk);
    frame_tick = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    rst = 1'b0;
    chk("midrst_posx", posx, 0);
    chk("midrst_posy", posy, 0);
    chk("midrst_vis", visible, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sliced", sliced, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
